// File: rtl/issue_unit_if.sv
// rtl/issue_unit_if.sv - issue unit queue-side handshake bundle
interface issue_unit_if #(
   parameter int RSV_DEPTH = 8
);
   logic                 cdb_flush;
   logic                 iq_int_rdy;
   logic                 iu_int_r_en;
   logic                 iq_ls_rdy;
   logic                 iu_ls_r_en;
   logic                 iq_mul_rdy;
   logic                 iu_mul_r_en;
   logic                 iq_div_rdy;
   logic                 iu_div_r_en;
   logic [RSV_DEPTH-1:0] iu_cdb_rsv;
   logic                 iu_div_busy;

   modport master (
      input  cdb_flush, iq_int_rdy, iq_ls_rdy, iq_mul_rdy, iq_div_rdy,
      output iu_int_r_en, iu_ls_r_en, iu_mul_r_en, iu_div_r_en,
      output iu_cdb_rsv, iu_div_busy
   );

   modport slave (
      output cdb_flush, iq_int_rdy, iq_ls_rdy, iq_mul_rdy, iq_div_rdy,
      input  iu_int_r_en, iu_ls_r_en, iu_mul_r_en, iu_div_r_en,
      input  iu_cdb_rsv, iu_div_busy
   );
endinterface

// File: rtl/issue_unit.sv
// rtl/issue_unit.sv - single-issue CDB-aware arbiter over int/ls/mul/div queues (option: IU_RR_ARB_EN)
module issue_unit #(
   parameter int INT_LAT   = 1,
   parameter int LS_LAT    = 2,
   parameter int MUL_LAT   = 4,
   parameter int DIV_LAT   = 8,
   parameter int RSV_DEPTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   issue_unit_if.master  bus
);

   localparam int CNT_W = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
   localparam logic [RSV_DEPTH-1:0] ONE = RSV_DEPTH'(1);

   // Bit to set in the next reservation vector when a unit issues: it lands at
   // index L-1 after the shift, i.e. vector bit L-2. Latency 1 reserves nothing.
   localparam logic [RSV_DEPTH-1:0] INT_SET =
      (INT_LAT >= 2) ? (ONE << ((INT_LAT >= 2) ? INT_LAT - 2 : 0)) : '0;
   localparam logic [RSV_DEPTH-1:0] LS_SET  =
      (LS_LAT  >= 2) ? (ONE << ((LS_LAT  >= 2) ? LS_LAT  - 2 : 0)) : '0;
   localparam logic [RSV_DEPTH-1:0] MUL_SET =
      (MUL_LAT >= 2) ? (ONE << ((MUL_LAT >= 2) ? MUL_LAT - 2 : 0)) : '0;
   localparam logic [RSV_DEPTH-1:0] DIV_SET =
      (DIV_LAT >= 2) ? (ONE << ((DIV_LAT >= 2) ? DIV_LAT - 2 : 0)) : '0;

   // rsv[k-1] set means the CDB is already claimed k cycles from now
   logic [RSV_DEPTH-1:0] rsv, rsv_next;
   logic [CNT_W-1:0]     div_cnt, div_cnt_next;
   logic                 elig_int, elig_ls, elig_mul, elig_div;
   logic                 gnt_int, gnt_ls, gnt_mul, gnt_div;

`ifdef IU_RR_ARB_EN
   logic                 rr_ls;
`endif

   assign elig_int = bus.iq_int_rdy & ~rsv[INT_LAT-1] & ~bus.cdb_flush;
   assign elig_ls  = bus.iq_ls_rdy  & ~rsv[LS_LAT-1]  & ~bus.cdb_flush;
   assign elig_mul = bus.iq_mul_rdy & ~rsv[MUL_LAT-1] & ~bus.cdb_flush;
   assign elig_div = bus.iq_div_rdy & ~rsv[DIV_LAT-1] & ~bus.cdb_flush
                     & (div_cnt == '0);

   // Priority select: longest latency first, int/ls tie broken last
   always_comb begin
      gnt_int = 1'b0;
      gnt_ls  = 1'b0;
      gnt_mul = 1'b0;
      gnt_div = 1'b0;
      if (!reset) begin
         if (elig_div)
            gnt_div = 1'b1;
         else if (elig_mul)
            gnt_mul = 1'b1;
         else if (elig_int && elig_ls) begin
`ifdef IU_RR_ARB_EN
            if (rr_ls)
               gnt_ls = 1'b1;
            else
               gnt_int = 1'b1;
`else
            gnt_int = 1'b1;
`endif
         end
         else if (elig_int)
            gnt_int = 1'b1;
         else if (elig_ls)
            gnt_ls = 1'b1;
      end
   end

   // Next reservation vector and divider countdown
   always_comb begin
      rsv_next = rsv >> 1;
      if (gnt_int) rsv_next = rsv_next | INT_SET;
      if (gnt_ls)  rsv_next = rsv_next | LS_SET;
      if (gnt_mul) rsv_next = rsv_next | MUL_SET;
      if (gnt_div) rsv_next = rsv_next | DIV_SET;
      div_cnt_next = div_cnt;
      if (gnt_div)
         div_cnt_next = CNT_W'(DIV_LAT - 1);
      else if (div_cnt != '0)
         div_cnt_next = div_cnt - 1'b1;
   end

   // CDB reservation and divider occupancy state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsv     <= '0;
         div_cnt <= '0;
      end
      else begin
         rsv     <= rsv_next;
         div_cnt <= div_cnt_next;
      end
   end

`ifdef IU_RR_ARB_EN
   // Pointer flips only when it actually resolved an int/ls contention
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rr_ls <= 1'b0;
      else if ((gnt_int || gnt_ls) && elig_int && elig_ls)
         rr_ls <= ~rr_ls;
   end
`endif

   assign bus.iu_int_r_en = gnt_int;
   assign bus.iu_ls_r_en  = gnt_ls;
   assign bus.iu_mul_r_en = gnt_mul;
   assign bus.iu_div_r_en = gnt_div;
   assign bus.iu_cdb_rsv  = rsv;
   assign bus.iu_div_busy = (div_cnt != '0);

endmodule

// File: tb/tb_issue_unit.sv
// tb/tb_issue_unit.sv - randomized self-checking bench for issue_unit
module tb_issue_unit;

   localparam int RSV     = 8;
   localparam int INT_LAT = 1;
   localparam int LS_LAT  = 2;
   localparam int MUL_LAT = 4;
   localparam int DIV_LAT = 8;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   // Model: absolute-cycle CDB calendar and divider free time
   logic taken [256];
   int   t;
   int   div_until;
   logic ptr_ls;

   issue_unit_if #(.RSV_DEPTH(RSV)) bus ();

   issue_unit #(
      .INT_LAT(INT_LAT), .LS_LAT(LS_LAT), .MUL_LAT(MUL_LAT),
      .DIV_LAT(DIV_LAT), .RSV_DEPTH(RSV)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic model_reset();
      for (int i = 0; i < 256; i++) taken[i] = 1'b0;
      t         = 0;
      div_until = 0;
      ptr_ls    = 1'b0;
   endtask

   task automatic drive(input logic [3:0] rdy, input logic fl);
      bus.iq_div_rdy = rdy[3];
      bus.iq_mul_rdy = rdy[2];
      bus.iq_ls_rdy  = rdy[1];
      bus.iq_int_rdy = rdy[0];
      bus.cdb_flush  = fl;
   endtask

   // One cycle: drive {div,mul,ls,int} rdy, compare against the calendar model at negedge
   task automatic step(input logic [3:0] rdy, input logic fl,
                       output logic [3:0] got_g, output logic [RSV-1:0] got_rsv);
      logic           ok_int, ok_ls, ok_mul, ok_div;
      logic [3:0]     exp_g;
      logic [RSV-1:0] exp_rsv;
      logic           exp_busy;
      drive(rdy, fl);
      @(negedge clk);
      ok_div = rdy[3] && !fl && (t >= div_until) && !taken[(t + DIV_LAT) % 256];
      ok_mul = rdy[2] && !fl && !taken[(t + MUL_LAT) % 256];
      ok_ls  = rdy[1] && !fl && !taken[(t + LS_LAT) % 256];
      ok_int = rdy[0] && !fl && !taken[(t + INT_LAT) % 256];
      exp_g = 4'b0000;
      if (ok_div)                 exp_g = 4'b1000;
      else if (ok_mul)            exp_g = 4'b0100;
      else if (ok_int && ok_ls) begin
`ifdef IU_RR_ARB_EN
         exp_g  = ptr_ls ? 4'b0010 : 4'b0001;
         ptr_ls = ~ptr_ls;
`else
         exp_g  = 4'b0001;
`endif
      end
      else if (ok_int)            exp_g = 4'b0001;
      else if (ok_ls)             exp_g = 4'b0010;
      for (int k = 1; k <= RSV; k++) exp_rsv[k-1] = taken[(t + k) % 256];
      exp_busy = (t < div_until);

      got_g   = {bus.iu_div_r_en, bus.iu_mul_r_en, bus.iu_ls_r_en, bus.iu_int_r_en};
      got_rsv = bus.iu_cdb_rsv;
      checks++;
      if (got_g !== exp_g) begin
         errors++;
         $display("FAIL grant t=%0d rdy=%b flush=%b: got %b expected %b", t, rdy, fl, got_g, exp_g);
      end
      checks++;
      if (got_rsv !== exp_rsv) begin
         errors++;
         $display("FAIL cdb_rsv t=%0d: got %b expected %b", t, got_rsv, exp_rsv);
      end
      checks++;
      if (bus.iu_div_busy !== exp_busy) begin
         errors++;
         $display("FAIL div_busy t=%0d: got %b expected %b", t, bus.iu_div_busy, exp_busy);
      end

      if (exp_g[3]) begin
         taken[(t + DIV_LAT) % 256] = 1'b1;
         div_until = t + DIV_LAT;
      end
      if (exp_g[2]) taken[(t + MUL_LAT) % 256] = 1'b1;
      if (exp_g[1]) taken[(t + LS_LAT) % 256]  = 1'b1;
      taken[t % 256] = 1'b0;
      t++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      logic [3:0]     g;
      logic [RSV-1:0] r;
      for (int i = 0; i < n; i++) step(4'b0000, 1'b0, g, r);
   endtask

   task automatic test_reset();
      drive(4'b1111, 1'b0);
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.iu_div_r_en, bus.iu_mul_r_en, bus.iu_ls_r_en, bus.iu_int_r_en} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_grants: got %b expected 0000",
                  {bus.iu_div_r_en, bus.iu_mul_r_en, bus.iu_ls_r_en, bus.iu_int_r_en});
      end
      checks++;
      if (bus.iu_cdb_rsv !== 8'h00) begin
         errors++;
         $display("FAIL reset_rsv: got %b expected 00000000", bus.iu_cdb_rsv);
      end
      checks++;
      if (bus.iu_div_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b expected 0", bus.iu_div_busy);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_divider_busy();
      logic [3:0]     g;
      logic [RSV-1:0] r;
      idle(9);
      for (int i = 0; i < 17; i++) begin
         step(4'b1000, 1'b0, g, r);
         checks++;
         if (g[3] !== ((i % 8) == 0)) begin
            errors++;
            $display("FAIL div_window i=%0d: got %b expected %b", i, g[3], ((i % 8) == 0));
         end
      end
   endtask

   task automatic test_collision();
      logic [3:0]     g;
      logic [RSV-1:0] r;
      idle(9);
      step(4'b1000, 1'b0, g, r);
      idle(3);
      step(4'b0101, 1'b0, g, r);
      checks++;
      if (g !== 4'b0001) begin
         errors++;
         $display("FAIL collision_c4: got %b expected 0001", g);
      end
      step(4'b0101, 1'b0, g, r);
      checks++;
      if (g !== 4'b0100) begin
         errors++;
         $display("FAIL collision_c5: got %b expected 0100", g);
      end
   endtask

   task automatic test_flush();
      logic [3:0]     g;
      logic [RSV-1:0] r;
      idle(9);
      step(4'b0100, 1'b0, g, r);
      step(4'b1111, 1'b1, g, r);
      checks++;
      if (g !== 4'b0000) begin
         errors++;
         $display("FAIL flush_grant: got %b expected 0000", g);
      end
      step(4'b0000, 1'b0, g, r);
      checks++;
      if (r !== 8'b0000_0010) begin
         errors++;
         $display("FAIL flush_shift: got %b expected 00000010", r);
      end
   endtask

   task automatic test_int_ls();
      logic [3:0]     g;
      logic [RSV-1:0] r;
      idle(9);
      for (int i = 0; i < 8; i++) begin
         step(4'b0011, 1'b0, g, r);
`ifdef IU_RR_ARB_EN
         if (i < 2) begin
            checks++;
            if (g !== ((i == 0) ? 4'b0001 : 4'b0010)) begin
               errors++;
               $display("FAIL rr_order i=%0d: got %b", i, g);
            end
         end
`else
         checks++;
         if (g !== 4'b0001) begin
            errors++;
            $display("FAIL int_fixed i=%0d: got %b expected 0001", i, g);
         end
`endif
      end
   endtask

   task automatic test_full_pipeline();
      logic [3:0]     g;
      logic [RSV-1:0] r;
      idle(9);
      for (int i = 0; i < 10; i++) begin
         step(4'b0101, 1'b0, g, r);
         checks++;
         if (g !== 4'b0100) begin
            errors++;
            $display("FAIL pipe_mul i=%0d: got %b expected 0100", i, g);
         end
         if (i >= 3) begin
            checks++;
            if (r[2:0] !== 3'b111) begin
               errors++;
               $display("FAIL pipe_rsv i=%0d: got %b expected 111", i, r[2:0]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [3:0]     g;
      logic [RSV-1:0] r;
      for (int i = 0; i < 1500; i++)
         step(4'($urandom), ($urandom_range(15) == 0), g, r);
   endtask

   task automatic test_reset_mid();
      logic [3:0]     g;
      logic [RSV-1:0] r;
      idle(9);
      step(4'b1000, 1'b0, g, r);
      drive(4'b1111, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.iu_div_r_en, bus.iu_mul_r_en, bus.iu_ls_r_en, bus.iu_int_r_en} !== 4'b0000) begin
         errors++;
         $display("FAIL midreset_grants: got %b expected 0000",
                  {bus.iu_div_r_en, bus.iu_mul_r_en, bus.iu_ls_r_en, bus.iu_int_r_en});
      end
      checks++;
      if (bus.iu_cdb_rsv !== 8'h00) begin
         errors++;
         $display("FAIL midreset_rsv: got %b expected 00000000", bus.iu_cdb_rsv);
      end
      checks++;
      if (bus.iu_div_busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_busy: got %b expected 0", bus.iu_div_busy);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      idle(3);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      drive(4'b0000, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      test_divider_busy();
      test_collision();
      test_flush();
      test_int_ls();
      test_full_pipeline();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
